// File: rtl/beep_sequencer_pkg.sv
// beep_sequencer_pkg: shared state encoding and 190 Hz default phase lengths
package beep_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, GAP = 2'd2} state_t;
  localparam int DEF_ON_TICKS = 38;
  localparam int DEF_OFF_TICKS = 38;
endpackage

// File: rtl/beep_sequencer_tick_timer.sv
// tick_timer: loadable down-counter that flags its final tick
module tick_timer #(
  parameter int W = 6
) (
  input  logic         clk190,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk190 or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign last = cnt_q == W'(1);
endmodule

// File: rtl/beep_sequencer.sv
// beep_sequencer: turns counted request pulses into timed buzzer beep patterns
module beep_sequencer
  import beep_sequencer_pkg::*;
#(
  parameter int ON_TICKS = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int CNT_W = 3
) (
  input  logic             clk190,
  input  logic             rst,
  input  logic             req,
  input  logic [CNT_W-1:0] count,
  input  logic             stop,
  output logic             buzzer,
  output logic             busy,
  output logic             done,
  output logic             overflow
);
  localparam int TW = $clog2((ON_TICKS > OFF_TICKS ? ON_TICKS : OFF_TICKS) + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d, pc_q, pc_d;
  logic pv_q, pv_d, done_q, done_d, ovf_q, ovf_d;
  logic load, last, new_req;
  logic [TW-1:0] load_val;
  assign new_req = req && count != '0;
  tick_timer #(.W(TW)) u_tmr (
    .clk190(clk190), .rst(rst), .load(load), .load_val(load_val), .last(last)
  );
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    pv_d = pv_q;
    pc_d = pc_q;
    done_d = 1'b0;
    ovf_d = 1'b0;
    load = 1'b0;
    load_val = '0;
    if (stop) begin
      state_d = IDLE;
      rem_d = '0;
      pv_d = 1'b0;
      pc_d = '0;
      load = 1'b1;
    end else if (state_q == IDLE) begin
      if (new_req) begin
        state_d = ON;
        rem_d = count;
        load = 1'b1;
        load_val = TW'(ON_TICKS);
      end
    end else begin
      if (new_req) begin
        ovf_d = pv_q;
        pv_d = 1'b1;
        pc_d = pv_q ? pc_q : count;
      end
      if (last && state_q == ON) begin
        state_d = GAP;
        rem_d = rem_q - 1'b1;
        load = 1'b1;
        load_val = TW'(OFF_TICKS);
      end else if (last && rem_q != '0) begin
        state_d = ON;
        load = 1'b1;
        load_val = TW'(ON_TICKS);
      end else if (last) begin
        // a request landing on the final gap tick has just been latched, so it starts here too
        done_d = 1'b1;
        state_d = pv_d ? ON : IDLE;
        rem_d = pv_d ? pc_d : '0;
        load = pv_d;
        load_val = pv_d ? TW'(ON_TICKS) : '0;
        pv_d = 1'b0;
        pc_d = '0;
      end
    end
  end
  always_ff @(posedge clk190 or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      pv_q <= 1'b0;
      pc_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      pv_q <= pv_d;
      pc_q <= pc_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  assign buzzer = state_q == ON;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign overflow = ovf_q;
endmodule

// File: doc/beep_sequencer.md
# beep_sequencer

Output-side counterpart to the button debouncer. It turns single-cycle event pulses (key press accepted, cycle finished, door fault, and so on) into timed buzzer patterns of N beeps on the clk190 domain. Each request is a one-cycle pulse carrying a beep count. The block produces ON/OFF beep phases and can hold one pending request while a pattern is already playing. It sits between the washing-machine control FSM and the buzzer pin.

## Interface
Parameters:
- ON_TICKS, default 38: clk190 cycles per beep-on phase (about 200 ms). Must be ≥1.
- OFF_TICKS, default 38: clk190 cycles per gap phase after each beep. Must be ≥1.
- CNT_W, default 3: width of the beep count. Maximum is 2^CNT_W−1 beeps.

Ports:
- clk190, input, 1: clock. Reset rst is asynchronous and active-high; clock is clk190.
- rst, input, 1: asynchronous active-high reset.
- req, input, 1: single-cycle request strobe, normally driven by a debounced pulse.
- count, input, CNT_W: number of beeps. Sampled only in a cycle where req=1.
- stop, input, 1: synchronous abort.
- buzzer, output, 1: buzzer drive. High during ON phases.
- busy, output, 1: a pattern is playing.
- done, output, 1: one-cycle pulse when a pattern completes normally.
- overflow, output, 1: one-cycle pulse when a request is dropped because the pending slot is full.

## Operation
- State machine: IDLE, ON, GAP. Registers:
  - tick counter, width $clog2(max(ON_TICKS,OFF_TICKS)+1);
  - remaining-beep counter, CNT_W bits;
  - pending slot: valid bit plus CNT_W count.
- IDLE, with req=1 and count≠0: load the remaining counter with count and the tick counter with ON_TICKS, then go to ON.
- Any state, req=1 with count=0: ignored. No state change, no done, no overflow.
- ON: decrement ticks. On the last tick, decrement the remaining counter, load OFF_TICKS, and go to GAP.
- GAP: decrement ticks. On the last tick:
  - if remaining≠0, go to ON;
  - else pulse done, then start the pending request if the slot is valid (straight to ON, slot cleared), otherwise go to IDLE.
- ON/GAP, with req=1 and count≠0:
  - slot empty: latch into the pending slot;
  - slot full: drop the request and pulse overflow. The slot keeps its original count (first-come).
- req that coincides with the final GAP tick while the slot is empty is latched into the slot. It then starts immediately, exactly as a pending request would.
- stop=1: next state IDLE, counters and pending slot cleared, no done. stop wins over a simultaneous req and over a simultaneous final GAP tick, so done is suppressed.
- Outputs are registered or decoded from registered state, never combinational from inputs:
  - buzzer = (state==ON);
  - busy = (state≠IDLE).

## Timing
- Reset values: state IDLE, buzzer 0, busy 0, done 0, overflow 0, pending slot invalid, all counters 0.
- Start latency: req sampled high at edge k moves the state to ON at edge k, so buzzer and busy are high from k to k+ON_TICKS.
- Pattern length for N beeps: N·(ON_TICKS+OFF_TICKS) cycles of busy. The trailing GAP is always played, which guarantees spacing between back-to-back patterns.
- done is high for exactly one cycle: the cycle after the final GAP edge, aligned with busy falling. With a pending start, busy stays high through that cycle and the next pattern's buzzer rises in the same cycle that done is high.
- overflow is high for exactly one cycle, the cycle after the edge that sampled the dropped req.
- stop sampled at edge k: buzzer and busy are low from k.
- Asynchronous rst mid-pattern: all outputs drop to 0 immediately and the pending slot is lost.

## Structure
- Shared package (or header with constants): state encoding localparams IDLE/ON/GAP, and default tick values for the 190 Hz clock.
- One natural sub-module: `tick_timer`, a loadable down-counter with a last-tick flag. It is reused for the ON and GAP phases and is reusable by the wash/rinse timers elsewhere.
- Everything else stays flat: the FSM, the remaining counter and the pending slot.

## Test plan
All scenarios use ON_TICKS=3, OFF_TICKS=2.
- Reset, then req with count=2 → buzzer pattern 111 00 111 00; busy high for 10 cycles; done one cycle when busy falls; overflow stays 0.
- req with count=0 while idle → buzzer, busy, done and overflow all stay 0.
- req count=1, then req count=2 during ON, then req count=3 during GAP → pattern 111 00 | 111 00 111 00; overflow pulses once, on the third req; done pulses twice; busy is continuous for 15 cycles.
- req count=3, then stop on the second cycle of the second ON → buzzer low from the next cycle, busy 0, no done; a later req count=1 plays normally.
- req count=1 coinciding with the final GAP tick of a running pattern → latched and started back-to-back (buzzer rises in the cycle that done is high), with no overflow.
- rst asserted mid-ON with a pending slot full → outputs go to 0 asynchronously; after release, nothing plays until a new req.
